// File: rtl/adc_capture_pkg.sv
// -----------------------------------------------------------------------------
// adc_capture_pkg
// Shared types and width helpers for the ADC snapshot engine.
//   capture_state_e : engine state encoding
//   idx_w()         : index width for an N-entry select (never less than 1)
//   CH_W / ADDR_W   : widths for the default configuration (2 channels, 1024 deep)
// -----------------------------------------------------------------------------
package adc_capture_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } capture_state_e;

    // A single-entry select still needs a 1-bit port.
    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    localparam int DEF_NUM_CH = 2;
    localparam int DEF_DEPTH  = 1024;
    localparam int CH_W       = idx_w(DEF_NUM_CH);
    localparam int ADDR_W     = $clog2(DEF_DEPTH);

endpackage

// File: rtl/adc_capture_ram.sv
// -----------------------------------------------------------------------------
// adc_capture_ram
// Simple dual-port sample store: one write port carrying all channels of a
// sample, one read port with a registered output. The array has no reset so it
// maps onto block RAM; only the output register is reset.
//   i_clk, i_rst        : clock, async active-high reset (output register only)
//   i_we/i_waddr/i_wdata: write port
//   i_raddr             : read address, data appears on o_rdata next cycle
//   o_rdata             : registered read word (old data on same-address write)
// -----------------------------------------------------------------------------
module adc_capture_ram #(
    parameter int W      = 24,
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 10
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [W-1:0]      i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [W-1:0]      o_rdata
);

    logic [W-1:0] r_mem [0:DEPTH-1];
    logic [W-1:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_we)
            r_mem[i_waddr] <= i_wdata;
    end

    // Read-before-write: a same-cycle write to i_raddr is not visible here.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_rdata <= '0;
        else
            r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/adc_capture.sv
// -----------------------------------------------------------------------------
// adc_capture
// Armable, triggered, decimated snapshot of NUM_CH ADC channels into RAM.
//   sys_clk, sys_rst        : clock, async active-high reset
//   adc_data, adc_valid     : lockstep channel samples, channel c at [c*DATA_W +: DATA_W]
//   arm, abort              : control pulses (abort wins over arm)
//   trig_mode/ch/level      : 0 = immediate, 1 = rising crossing on trig_ch
//   decim                   : keep one of every decim+1 valid samples
//   rd_addr, rd_ch, rd_data : readout, one cycle latency
//   busy, done, wr_count    : status
// Configuration inputs are latched at arm and ignored afterwards.
// -----------------------------------------------------------------------------
module adc_capture
    import adc_capture_pkg::*;
#(
    parameter int NUM_CH  = 2,
    parameter int DATA_W  = 12,
    parameter int DEPTH   = 1024,
    parameter int DECIM_W = 16
) (
    input  logic                       sys_clk,
    input  logic                       sys_rst,
    input  logic [NUM_CH*DATA_W-1:0]   adc_data,
    input  logic                       adc_valid,
    input  logic                       arm,
    input  logic                       abort,
    input  logic                       trig_mode,
    input  logic [idx_w(NUM_CH)-1:0]   trig_ch,
    input  logic [DATA_W-1:0]          trig_level,
    input  logic [DECIM_W-1:0]         decim,
    input  logic [$clog2(DEPTH)-1:0]   rd_addr,
    input  logic [idx_w(NUM_CH)-1:0]   rd_ch,
    output logic [DATA_W-1:0]          rd_data,
    output logic                       busy,
    output logic                       done,
    output logic [$clog2(DEPTH):0]     wr_count
);

    localparam int C_CH_W   = idx_w(NUM_CH);
    localparam int C_ADDR_W = $clog2(DEPTH);

    capture_state_e          r_state;
    logic                    r_busy;
    logic                    r_done;
    logic [C_ADDR_W:0]       r_wr_count;
    logic [DECIM_W-1:0]      r_decim;
    logic [DECIM_W-1:0]      r_dcnt;
    logic                    r_trig_mode;
    logic [C_CH_W-1:0]       r_trig_ch;
    logic [DATA_W-1:0]       r_trig_level;
    logic [DATA_W-1:0]       r_prev;
    logic                    r_have_prev;
    logic [C_CH_W-1:0]       r_rd_ch;

    logic [DATA_W-1:0]        w_trig_smp;
    logic                     w_trig_hit;
    logic                     w_accept;
    logic                     w_we;
    logic                     w_last;
    logic [DECIM_W-1:0]       w_dcnt_next;
    logic [NUM_CH*DATA_W-1:0] w_rd_word;

    // Trigger channel select; an out-of-range index reads as zero.
    always_comb begin
        w_trig_smp = '0;
        for (int c = 0; c < NUM_CH; c++)
            if (r_trig_ch == C_CH_W'(c))
                w_trig_smp = adc_data[c*DATA_W +: DATA_W];
    end

    // Rising crossing needs a previous valid sample, so the first one after
    // arm can only seed r_prev.
    assign w_trig_hit  = (r_state == ARMED) && r_trig_mode && adc_valid && r_have_prev &&
                         (r_prev < r_trig_level) && (w_trig_smp >= r_trig_level);
    assign w_accept    = (r_state == CAPTURE) && adc_valid && (r_dcnt == '0);
    assign w_we        = !abort && (w_trig_hit || w_accept);
    assign w_last      = (r_wr_count == (C_ADDR_W+1)'(DEPTH-1));
    assign w_dcnt_next = (r_dcnt == r_decim) ? '0 : r_dcnt + 1'b1;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state      <= IDLE;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_wr_count   <= '0;
            r_decim      <= '0;
            r_dcnt       <= '0;
            r_trig_mode  <= 1'b0;
            r_trig_ch    <= '0;
            r_trig_level <= '0;
            r_prev       <= '0;
            r_have_prev  <= 1'b0;
        end else if (abort) begin
            // wr_count and RAM are left as-is so a partial capture can be read.
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (arm) begin
                        r_state      <= ARMED;
                        r_busy       <= 1'b1;
                        r_done       <= 1'b0;
                        r_wr_count   <= '0;
                        r_dcnt       <= '0;
                        r_have_prev  <= 1'b0;
                        r_decim      <= decim;
                        r_trig_mode  <= trig_mode;
                        r_trig_ch    <= trig_ch;
                        r_trig_level <= trig_level;
                    end
                end
                ARMED: begin
                    if (!r_trig_mode) begin
                        r_state <= CAPTURE;
                    end else if (w_trig_hit) begin
                        // Trigger sample is stored this cycle as index 0 and
                        // counts as decimation slot 0.
                        r_state <= CAPTURE;
                        r_dcnt  <= (r_decim == '0) ? '0 : DECIM_W'(1);
                    end else if (adc_valid) begin
                        r_prev      <= w_trig_smp;
                        r_have_prev <= 1'b1;
                    end
                end
                CAPTURE: begin
                    if (adc_valid)
                        r_dcnt <= w_dcnt_next;
                    if (w_accept && w_last) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
            // Never coincides with the clear on arm: writes happen only when busy.
            if (w_we)
                r_wr_count <= r_wr_count + 1'b1;
        end
    end

    adc_capture_ram #(
        .W      (NUM_CH*DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (C_ADDR_W)
    ) u_ram (
        .i_clk   (sys_clk),
        .i_rst   (sys_rst),
        .i_we    (w_we),
        .i_waddr (r_wr_count[C_ADDR_W-1:0]),
        .i_wdata (adc_data),
        .i_raddr (rd_addr),
        .o_rdata (w_rd_word)
    );

    // Channel index is registered alongside the RAM read so the select lines
    // up with the word it picks from; rd_data depends on registers only.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst)
            r_rd_ch <= '0;
        else
            r_rd_ch <= rd_ch;
    end

    always_comb begin
        rd_data = '0;
        for (int c = 0; c < NUM_CH; c++)
            if (r_rd_ch == C_CH_W'(c))
                rd_data = w_rd_word[c*DATA_W +: DATA_W];
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign wr_count = r_wr_count;

endmodule

// File: tb/tb_adc_capture.sv
module tb_adc_capture;

    localparam int NUM_CH = 2;
    localparam int DATA_W = 12;
    localparam int DEPTH  = 16;
    localparam int DECIM_W = 16;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic [23:0] adc_data;
    logic        adc_valid;
    logic        arm, abort, trig_mode;
    logic [0:0]  trig_ch, rd_ch;
    logic [11:0] trig_level;
    logic [15:0] decim;
    logic [3:0]  rd_addr;
    logic [11:0] rd_data;
    logic        busy, done;
    logic [4:0]  wr_count;

    adc_capture #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .DEPTH(DEPTH), .DECIM_W(DECIM_W)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .adc_data(adc_data), .adc_valid(adc_valid),
        .arm(arm), .abort(abort), .trig_mode(trig_mode), .trig_ch(trig_ch),
        .trig_level(trig_level), .decim(decim), .rd_addr(rd_addr), .rd_ch(rd_ch),
        .rd_data(rd_data), .busy(busy), .done(done), .wr_count(wr_count)
    );

    always #5 sys_clk = ~sys_clk;

    int n_chk = 0;
    int n_fail = 0;

    // scoreboard: one packed {ch1,ch0} word per stored sample, in address order
    logic [23:0] q[$];
    logic [11:0] rb0 [0:15];
    logic [11:0] rb1 [0:15];
    logic [11:0] g;
    int          busy_cyc;

    // reference model state (0 idle, 1 armed, 2 capture, 3 done)
    int          m_st, m_cnt, m_dc, m_decim;
    logic        m_mode, m_tch, m_hp;
    logic [11:0] m_lvl, m_prev;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic m_store();
        q.push_back(adc_data);
        m_cnt++;
        if (m_cnt == DEPTH) m_st = 3;
    endtask

    task automatic model_tick();
        logic [11:0] cur;
        if (abort) begin
            m_st = 0;
        end else begin
            case (m_st)
                0, 3: if (arm) begin
                    m_st = 1; m_cnt = 0; m_dc = 0; m_hp = 1'b0;
                    m_decim = int'(decim); m_mode = trig_mode; m_tch = trig_ch[0]; m_lvl = trig_level;
                end
                1: if (!m_mode) m_st = 2;
                   else if (adc_valid) begin
                       cur = m_tch ? adc_data[23:12] : adc_data[11:0];
                       if (m_hp && m_prev < m_lvl && cur >= m_lvl) begin
                           m_st = 2;
                           m_store();
                           m_dc = (m_decim == 0) ? 0 : 1;
                       end else begin
                           m_prev = cur; m_hp = 1'b1;
                       end
                   end
                2: if (adc_valid) begin
                       if (m_dc == 0) m_store();
                       m_dc = (m_dc == m_decim) ? 0 : m_dc + 1;
                   end
                default: m_st = 0;
            endcase
        end
    endtask

    // Drive one cycle, advance the model at the edge, check status at the negedge.
    task automatic step(input logic v, input logic [11:0] a, input logic [11:0] b);
        adc_valid = v;
        adc_data  = {b, a};
        @(posedge sys_clk);
        model_tick();
        @(negedge sys_clk);
        chk("busy", busy, (m_st == 1 || m_st == 2));
        chk("done", done, (m_st == 3));
        chk("wr_count", wr_count, m_cnt);
        arm   = 1'b0;
        abort = 1'b0;
    endtask

    task automatic ramp(input logic v);
        step(v, g, 12'hFFF - g);
        g = g + 12'd1;
    endtask

    task automatic rdw(input int addr, input int ch, output logic [11:0] val);
        rd_addr = addr[3:0];
        rd_ch   = ch[0:0];
        step(1'b0, 12'h0, 12'h0);
        val = rd_data;
    endtask

    task automatic readback(input int n, input string tag);
        logic [23:0] e;
        logic [11:0] v;
        for (int k = 0; k < n; k++) begin
            chk({tag, "_qsize"}, (q.size() > 0), 1);
            e = (q.size() > 0) ? q.pop_front() : 24'h0;
            rdw(k, 0, v); rb0[k] = v; chk({tag, "_ch0"}, v, e[11:0]);
            rdw(k, 1, v); rb1[k] = v; chk({tag, "_ch1"}, v, e[23:12]);
        end
    endtask

    initial begin
        logic [11:0] v;
        sys_rst = 1'b1; adc_data = '0; adc_valid = 1'b0; arm = 1'b0; abort = 1'b0;
        trig_mode = 1'b0; trig_ch = '0; trig_level = '0; decim = '0; rd_addr = '0; rd_ch = '0;
        m_st = 0; m_cnt = 0; m_dc = 0; m_decim = 0; m_mode = 0; m_tch = 0; m_hp = 0; m_lvl = 0; m_prev = 0;
        g = '0;
        repeat (2) @(negedge sys_clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_wr_count", wr_count, 0);
        chk("rst_rd_data", rd_data, 0);
        sys_rst = 1'b0;
        @(negedge sys_clk);

        // immediate capture, every sample kept
        arm = 1'b1; ramp(1'b1);
        for (int i = 0; i < 40 && !done; i++) ramp(1'b1);
        chk("t1_done", done, 1);
        chk("t1_wr_count", wr_count, 16);
        readback(16, "t1");
        for (int k = 1; k < 16; k++) begin
            chk("t1_ramp", rb0[k], rb0[0] + 12'(k));
            chk("t1_compl", rb1[k], 12'hFFF - rb0[k]);
        end

        // decimation by 4; a mid-capture decim change must be ignored
        decim = 16'd3; arm = 1'b1; ramp(1'b1);
        busy_cyc = busy ? 1 : 0;
        for (int i = 0; i < 120 && !done; i++) begin
            if (i == 10) decim = 16'd0;
            ramp(1'b1);
            if (busy) busy_cyc++;
        end
        chk("t3_done", done, 1);
        chk("t3_busy_len", (busy_cyc >= 58 && busy_cyc <= 68), 1);
        readback(16, "t3");
        for (int k = 1; k < 16; k++) chk("t3_step4", rb0[k] - rb0[k-1], 12'd4);

        // rising level trigger on channel 1
        decim = 16'd0; trig_mode = 1'b1; trig_ch = 1'b1; trig_level = 12'h800;
        arm = 1'b1; step(1'b1, 12'h0, 12'h900);
        step(1'b1, 12'h1, 12'h900);
        step(1'b1, 12'h2, 12'h900);
        chk("t4_above_no_trig", wr_count, 0);
        for (int i = 0; i < 16; i++) step(1'b1, 12'(i), 12'h7F0 + 12'(i));
        chk("t4_below_busy", busy, 1);
        chk("t4_below_wr", wr_count, 0);
        for (int i = 0; i < 40 && !done; i++) step(1'b1, 12'h100 + 12'(i), 12'h800 + 12'(i));
        chk("t4_done", done, 1);
        readback(16, "t4");
        rdw(0, 1, v); chk("t4_idx0", v, 12'h800);
        rdw(15, 1, v); chk("t4_idx15", v, 12'h80F);
        trig_mode = 1'b0;

        // valid toggling: gaps are neither stored nor counted
        arm = 1'b1; ramp(1'b1);
        for (int i = 0; i < 80 && !done; i++) ramp(1'((i % 2) == 0));
        chk("t5_done", done, 1);
        chk("t5_wr_count", wr_count, 16);
        readback(16, "t5");
        for (int k = 1; k < 16; k++) chk("t5_step2", rb0[k] - rb0[k-1], 12'd2);

        // arm ignored while capturing, abort at 5, arm+abort stays idle
        arm = 1'b1; ramp(1'b1);
        for (int i = 0; i < 40 && wr_count != 5'd3; i++) ramp(1'b1);
        arm = 1'b1; ramp(1'b1);
        chk("t6_arm_ignored_busy", busy, 1);
        chk("t6_arm_ignored_wr", wr_count, 4);
        ramp(1'b1);
        abort = 1'b1; ramp(1'b1);
        chk("t6_abort_busy", busy, 0);
        chk("t6_abort_done", done, 0);
        chk("t6_abort_wr", wr_count, 5);
        arm = 1'b1; abort = 1'b1; ramp(1'b1);
        chk("t6_armabort_busy", busy, 0);
        ramp(1'b1);
        chk("t6_armabort_idle", busy, 0);
        chk("t6_armabort_wr", wr_count, 5);
        readback(5, "t6");

        // async reset mid-capture, then a fresh complete capture
        arm = 1'b1; ramp(1'b1);
        repeat (6) ramp(1'b1);
        #2 sys_rst = 1'b1;
        #1;
        chk("t7_rst_busy", busy, 0);
        chk("t7_rst_done", done, 0);
        chk("t7_rst_wr", wr_count, 0);
        chk("t7_rst_rd", rd_data, 0);
        m_st = 0; m_cnt = 0;
        q.delete();
        @(negedge sys_clk);
        sys_rst = 1'b0;
        @(negedge sys_clk);
        arm = 1'b1; ramp(1'b1);
        for (int i = 0; i < 40 && !done; i++) ramp(1'b1);
        chk("t7_done", done, 1);
        chk("t7_wr_count", wr_count, 16);
        readback(16, "t7");
        chk("q_empty", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/adc_capture.md
# adc_capture

Multi-channel, parametrised ADC snapshot engine for the uberClock SoC. It sits between the ADC front-end (`adc`) and the CSR block. It replaces the single-register "latest sample" path with armable, triggered, decimated capture of `DEPTH` samples per channel into on-chip RAM. The CPU arms a capture, polls status, then reads samples back over a random-access read port.

## Interface
Parameters:
- `NUM_CH`, 2, number of ADC channels captured in lockstep (1..8)
- `DATA_W`, 12, sample width; samples are offset-binary (unsigned)
- `DEPTH`, 1024, samples stored per channel; power of two, ≥ 4
- `DECIM_W`, 16, width of the decimation setting

Ports:
- `sys_clk`  in  1  system clock; the only clock
- `sys_rst`  in  1  reset, asynchronous and active-high
- `adc_data`  in  NUM_CH*DATA_W  channel c occupies bits [c*DATA_W +: DATA_W]
- `adc_valid`  in  1  qualifies `adc_data` this cycle
- `arm`  in  1  single-cycle pulse that starts a capture
- `abort`  in  1  single-cycle pulse that returns the engine to IDLE
- `trig_mode`  in  1  0 = immediate; 1 = rising level crossing
- `trig_ch`  in  $clog2(NUM_CH) (min 1)  channel compared against `trig_level`
- `trig_level`  in  DATA_W  trigger threshold
- `decim`  in  DECIM_W  keep 1 of every `decim+1` valid samples
- `rd_addr`  in  $clog2(DEPTH)  sample index for readout
- `rd_ch`  in  $clog2(NUM_CH) (min 1)  channel for readout
- `rd_data`  out  DATA_W  registered read data
- `busy`  out  1  high in ARMED or CAPTURE
- `done`  out  1  high in DONE
- `wr_count`  out  $clog2(DEPTH)+1  samples stored in the current or last capture

## Operation
- States: IDLE, ARMED, CAPTURE, DONE.
- IDLE/DONE + `arm`:
  - go to ARMED
  - `wr_count` cleared to 0
  - decimation counter and trigger history cleared
- ARMED:
  - `trig_mode=0`: go to CAPTURE next cycle.
  - `trig_mode=1`: a sample on `trig_ch` triggers when `prev < trig_level` and `cur >= trig_level`, with both samples having `adc_valid`.
  - The first valid sample after arm only loads `prev`; it can never trigger.
  - The triggering sample is the first sample stored (index 0) and restarts decimation.
- Decimation:
  - A counter runs over valid samples only.
  - A sample is accepted when the counter is 0; the counter wraps at `decim`.
  - `decim=0` accepts every valid sample.
  - `decim` is sampled at `arm`; changes mid-capture are ignored. `trig_mode`, `trig_ch` and `trig_level` are sampled the same way.
- CAPTURE:
  - Each accepted sample writes all NUM_CH channels at address `wr_count[$clog2(DEPTH)-1:0]`, then `wr_count++`.
  - When `wr_count` reaches DEPTH, go to DONE. There is no wrap and no overwrite.
- DONE: stays there until `arm` or `abort`.
- `arm` while busy is ignored.
- `abort` in any state goes to IDLE. `wr_count` holds its value; RAM contents are kept.
- `abort` and `arm` in the same cycle: abort wins.
- Readout is legal in any state. During CAPTURE, not-yet-written addresses return stale data.

## Timing
- Reset values:
  - state IDLE
  - `busy`=0, `done`=0
  - `wr_count`=0
  - `rd_data`=0
  - RAM content undefined
- `busy` and `done` are registered; they reflect the state one cycle after the causing event.
- Immediate mode: `arm` at cycle N gives ARMED at N+1 and CAPTURE at N+2. The first sample written is the first accepted sample at or after N+2.
- Trigger mode: the trigger sample is written in the same cycle the FSM enters CAPTURE, with no sample lost.
- `wr_count` updates the cycle after the write. `done` rises the cycle after the DEPTH-th write.
- Read latency:
  - `rd_addr`/`rd_ch` presented at cycle N gives `rd_data` valid at N+1.
  - The output register is updated every cycle.
- A read and a write to the same address in the same cycle return old data.
- Reset asserted mid-capture forces IDLE immediately and asynchronously. All outputs return to reset values.

## Structure
- `adc_capture_pkg`:
  - `capture_state_e` enum (IDLE, ARMED, CAPTURE, DONE)
  - localparams `CH_W`, `ADDR_W`, computed from the parameters
- Sub-module `adc_capture_ram`:
  - simple dual-port: 1 write port of width NUM_CH*DATA_W, 1 registered read port
  - depth DEPTH, inferred as block RAM
  - no reset on the array
- Channel select mux on the read word, registered inside the top level.

## Test plan
- Immediate capture, NUM_CH=2, DEPTH=16, `decim=0`, ramp data ch0=i, ch1=0xFFF-i every cycle:
  - `done` rises after 16 accepted samples
  - `wr_count`=16
  - readback ch0[k]=first_value+k, ch1 complementary
- Decimation `decim=3`, continuous valid ramp: stored values step by 4; `busy` lasts ≈64 valid cycles.
- Level trigger `trig_ch`=1, `trig_level`=0x800, data rises 0x7F0→0x810:
  - no capture while data stays below the threshold
  - index 0 holds the first sample ≥0x800
  - a first sample already above the threshold does not trigger
- `adc_valid` toggling 1-0-1: only valid samples are counted and stored; gaps do not advance `wr_count`.
- `abort` mid-capture at `wr_count`=5:
  - IDLE next cycle, `busy`=0, `done`=0, `wr_count` holds 5
  - `arm`+`abort` in the same cycle stays IDLE
  - `arm` during CAPTURE is ignored
- Async `sys_rst` pulse mid-capture: all outputs go to 0 at once; a fresh `arm` completes normally.
